dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serialises 12-bit waveform samples from the wave-compute stage into 16-bit SPI frames for an MCP4921-class 12-bit DAC. A one-entry holding register decouples the sample producer from the serial link, so the next sample can be accepted while the current frame is shifting. It sits directly downstream of the amplitude-scaled sine output and drives the board DAC pins.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period; minimum 1.
- CFG_BITS, 4'b0111: frame bits [15:12], covering channel A, buffered Vref, 1x gain and active output.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- in_sample  in  12  sample to convert.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  holding register is empty.
- busy  out  1  a frame is in progress (any state other than IDLE).
- dac_cs_n  out  1  chip select, active low.
- dac_sclk  out  1  serial clock, idles low (SPI mode 0).
- dac_mosi  out  1  serial data, MSB first.
- dac_ldac_n  out  1  latch strobe, active low. Tied high unless DAC_LDAC_EN is defined.

## Operation
- A sample is accepted on a clk edge where in_valid && in_ready. The holding register is full from the next cycle, and in_ready is low while it is full.
- Frame layout: {CFG_BITS, sample[11:0]}, 16 bits, shifted MSB first.
- States:
  - IDLE: if the holding register is full, load the shift register, clear the holding register and go to CS_SETUP.
  - CS_SETUP: cs_n low, mosi = bit 15, sclk low, for D cycles. Then go to SHIFT.
  - SHIFT: 32 half-periods of D cycles each. sclk rises at odd half-periods. On each falling edge mosi advances to the next bit. After the 16th high half-period sclk returns low; go to CS_HOLD.
  - CS_HOLD: cs_n low, sclk low, for D cycles.
  - GAP: cs_n high for D cycles. Then go to LDAC if DAC_LDAC_EN is defined, otherwise IDLE.
  - LDAC: only exists with DAC_LDAC_EN. dac_ldac_n low for D cycles, then IDLE.
- A single half-period counter of width $clog2(CLK_DIV)+1 sets all D-cycle intervals. A 5-bit counter tracks half-periods.
- in_ready rises the cycle after IDLE→CS_SETUP, so a second sample can be queued during the frame.
- in_valid while in_ready is low has no effect. The producer must hold in_valid.
- Reset values: cs_n=1, sclk=0, mosi=0, ldac_n=1, in_ready=1, busy=0, state IDLE, holding register empty.
- Reset mid-frame: on the next edge cs_n goes high and sclk low. The frame is abandoned, the holding register is cleared, and no LDAC pulse is issued.

## Timing
- With D=CLK_DIV and no LDAC, a frame is 35·D cycles: cs_n is low for 34·D cycles, followed by D cycles high.
- With DAC_LDAC_EN, a frame is 36·D cycles.
- Accept-to-cs_n-low latency is 2 cycles when idle: one cycle to fill the holding register, one for IDLE→CS_SETUP.
- Back-to-back frames: when the holding register is full at GAP/LDAC exit, the next cs_n falls 1 cycle after IDLE is entered.
- mosi is stable for ≥D cycles around every sclk rising edge.
- Maximum sample rate is f_clk/(35·D+1) without LDAC and f_clk/(36·D+1) with it. The producer must not exceed this rate, or it stalls on in_ready.

## Configuration
- DAC_LDAC_EN defined: the LDAC state exists and dac_ldac_n pulses low for D cycles after each frame. Set the DAC to latch only on LDAC so that channel updates occur at deterministic times.
- DAC_LDAC_EN undefined: the LDAC state is absent, dac_ldac_n is constant 1, and the DAC latches on the cs_n rising edge.

## Structure
- Shared package dac_pkg:
  - state enum dac_state_t (IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LDAC).
  - FRAME_W=16, SAMPLE_W=12, DAC_CFG_DEFAULT=4'b0111.
- One sub-module spi_tick_gen: a CLK_DIV-cycle tick generator, restartable on state entry, with a synchronous reset.

## Test plan
- Reset, then one sample 12'hABC with CLK_DIV=2 → cs_n low for 68 cycles. The 16 bits captured on sclk rising edges equal 16'h7ABC. Then cs_n stays high for 2 cycles and busy drops.
- Offer 12'h001 then 12'hFFF back-to-back → the second sample is accepted during frame 1 (in_ready low until frame 1 reaches CS_SETUP). Frames carry 16'h7001 and 16'h7FFF, and the cs_n rising→falling gap is 3 cycles.
- Assert reset at cycle 20 of a frame → next cycle cs_n=1, sclk=0, in_ready=1, busy=0. A later sample 12'h555 produces a clean 16'h7555 frame.
- CLK_DIV=1, sample 12'h800 → 32 sclk half-periods of 1 cycle each, 35-cycle frame, frame value 16'h7800.
- DAC_LDAC_EN defined, CLK_DIV=2, sample 12'h123 → dac_ldac_n low for exactly 2 cycles, starting 2 cycles after cs_n rises. Undefined: dac_ldac_n is constantly 1.
- in_valid held high with in_ready low for a whole frame → exactly one extra sample is captured. No samples are dropped or duplicated across 10 consecutive frames.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC serial transmitter.
package dac_pkg;

  localparam int FRAME_W  = 16;
  localparam int SAMPLE_W = 12;

  // Channel A, buffered Vref, 1x gain, output active
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP,
    LDAC
  } dac_state_t;

  // The frame is the four config bits followed by the sample
  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0]          cfg,
                                                    input logic [SAMPLE_W-1:0] sample);
    return {cfg, sample};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Restartable CLK_DIV-cycle tick generator. A down-counter reloads on
// restart or terminal count; tick is the terminal-count compare, so the
// first tick after a restart arrives on the CLK_DIV-th cycle.
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int              CW     = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Down-count to zero, reload on terminal count or restart
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// 12-bit sample to 16-bit SPI frame serialiser for an MCP4921-class DAC,
// SPI mode 0, MSB first, with a one-entry holding register in front.
// Optional feature macro: DAC_LDAC_EN adds an LDAC strobe state after
// each frame; without it dac_ldac_n is constant 1.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | link quiet; start a frame when the holding reg is full
//  CS_SETUP | cs_n low, bit 15 on mosi, sclk low, D cycles
//  SHIFT    | 32 half-periods of D cycles; sclk high on odd ones
//  CS_HOLD  | cs_n low, sclk low, D cycles after the last falling edge
//  GAP      | cs_n high for D cycles (DAC latches here without LDAC)
//  LDAC     | dac_ldac_n low for D cycles (DAC_LDAC_EN builds only)
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter logic [3:0] CFG_BITS = DAC_CFG_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                dac_ldac_n
);

  dac_state_t          state, state_nxt;
  logic                hold_full;
  logic [SAMPLE_W-1:0] hold_data;
  logic [FRAME_W-1:0]  sreg;
  logic [4:0]          hp;
  logic                tick;
  logic                restart;
  logic                load;

  // Every interval restarts from a full count whenever the state changes
  assign restart = (state_nxt != state);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pin decode
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    dac_cs_n   = 1'b1;
    dac_sclk   = 1'b0;
    dac_mosi   = 1'b0;
    dac_ldac_n = 1'b1;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = CS_SETUP;
        end
      end
      CS_SETUP: begin
        dac_cs_n = 1'b0;
        dac_mosi = sreg[FRAME_W-1];
        if (tick) state_nxt = SHIFT;
      end
      SHIFT: begin
        dac_cs_n = 1'b0;
        dac_mosi = sreg[FRAME_W-1];
        dac_sclk = hp[0];
        if (tick && (hp == 5'd31)) state_nxt = CS_HOLD;
      end
      CS_HOLD: begin
        dac_cs_n = 1'b0;
        if (tick) state_nxt = GAP;
      end
      GAP: begin
`ifdef DAC_LDAC_EN
        if (tick) state_nxt = LDAC;
`else
        if (tick) state_nxt = IDLE;
`endif
      end
      LDAC: begin
`ifdef DAC_LDAC_EN
        dac_ldac_n = 1'b0;
        if (tick) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-entry holding register; the frame start empties it
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (in_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= in_sample;
    end
  end

  // Shift register and half-period count; mosi advances on each falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      hp   <= '0;
    end else if (load) begin
      sreg <= make_frame(CFG_BITS, hold_data);
      hp   <= '0;
    end else if ((state == SHIFT) && tick) begin
      hp <= hp + 5'd1;
      if (hp[0]) sreg <= {sreg[FRAME_W-2:0], 1'b0};
    end
  end

  assign in_ready = !hold_full;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: instance 0 at CLK_DIV=2, instance 1 at
// CLK_DIV=1. A pin monitor rebuilds each frame from the SPI pins.
module tb_dac_spi_tx;

`ifdef DAC_LDAC_EN
  localparam int LD = 1;
`else
  localparam int LD = 0;
`endif
  localparam int D0 = 2;
  localparam int D1 = 1;

  logic        clk;
  logic        reset;
  logic [11:0] in_sample [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        busy      [2];
  logic        cs_n      [2];
  logic        sclk      [2];
  logic        mosi      [2];
  logic        ldac_n    [2];

  int n_chk;
  int n_err;
  int cyc;

  dac_spi_tx #(.CLK_DIV(D0)) dut0 (
    .clk(clk), .reset(reset), .in_sample(in_sample[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .busy(busy[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
    .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0])
  );

  dac_spi_tx #(.CLK_DIV(D1)) dut1 (
    .clk(clk), .reset(reset), .in_sample(in_sample[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .busy(busy[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
    .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Pin monitor state
  logic [15:0] sh [2];
  int nb [2], low [2], edges [2], rise_cyc [2], fall_cyc [2], gap_pend [2];
  int fr_n [2], ldac_ofs [2], ldac_len [2], ldac_total [2], ldac_pulses [2], idle_dly [2];
  logic [15:0] fr_val   [2][32];
  int          fr_bits  [2][32];
  int          fr_low   [2][32];
  int          fr_edges [2][32];
  int          fr_gap   [2][32];
  logic cs_p [2], sclk_p [2], ldac_p [2], busy_p [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0; nb[i] = 0; low[i] = 0; edges[i] = 0; rise_cyc[i] = 0; fall_cyc[i] = 0;
      gap_pend[i] = 0; fr_n[i] = 0; ldac_ofs[i] = 0; ldac_len[i] = 0; ldac_total[i] = 0;
      ldac_pulses[i] = 0; idle_dly[i] = 0;
      cs_p[i] = 1'b1; sclk_p[i] = 1'b0; ldac_p[i] = 1'b1; busy_p[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!cs_n[i] && cs_p[i]) begin
          fall_cyc[i] = cyc;
          gap_pend[i] = cyc - rise_cyc[i];
          sh[i] = '0; nb[i] = 0; low[i] = 0; edges[i] = 0;
        end
        if (!cs_n[i]) begin
          low[i]++;
          if (sclk[i] != sclk_p[i]) edges[i]++;
          if (sclk[i] && !sclk_p[i]) begin
            sh[i] = {sh[i][14:0], mosi[i]};
            nb[i]++;
          end
        end
        if (cs_n[i] && !cs_p[i]) begin
          if (fr_n[i] < 32) begin
            fr_val[i][fr_n[i]]   = sh[i];
            fr_bits[i][fr_n[i]]  = nb[i];
            fr_low[i][fr_n[i]]   = low[i];
            fr_edges[i][fr_n[i]] = edges[i];
            fr_gap[i][fr_n[i]]   = gap_pend[i];
            fr_n[i]++;
          end
          rise_cyc[i] = cyc;
        end
        if (!ldac_n[i] && ldac_p[i]) begin
          ldac_ofs[i] = cyc - rise_cyc[i];
          ldac_len[i] = 0;
          ldac_pulses[i]++;
        end
        if (!ldac_n[i]) begin
          ldac_len[i]++;
          ldac_total[i]++;
        end
        if (!busy[i] && busy_p[i]) idle_dly[i] = cyc - rise_cyc[i];
        cs_p[i] = cs_n[i]; sclk_p[i] = sclk[i]; ldac_p[i] = ldac_n[i]; busy_p[i] = busy[i];
      end
    end
  end

  // Offer a sample, holding in_valid until accepted; acc is the cycle of the
  // negedge before the accepting edge
  task automatic send(input int i, input logic [11:0] s, output int acc);
    int b;
    b = 0;
    in_sample[i] = s;
    in_valid[i]  = 1'b1;
    while (!in_ready[i] && b < 500) begin
      @(negedge clk);
      b++;
    end
    acc = cyc;
    chk("send_ready", in_ready[i], 1);
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n);
    int b;
    b = 0;
    while (fr_n[i] < n && b < 5000) begin
      @(negedge clk);
      b++;
    end
    chk("frame_count", fr_n[i], n);
    b = 0;
    while (busy[i] && b < 500) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
  endtask

  logic [11:0] smp [10] = '{12'h0F0, 12'h1E1, 12'h2D2, 12'h3C3, 12'h4B4,
                            12'h5A5, 12'h696, 12'h787, 12'h878, 12'h969};
  logic [15:0] exf [10] = '{16'h70F0, 16'h71E1, 16'h72D2, 16'h73C3, 16'h74B4,
                            16'h75A5, 16'h7696, 16'h7787, 16'h7878, 16'h7969};

  initial begin
    int a0, a1, a2;
    int acc [10];
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_sample[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n[0], 1);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_ldac_n", ldac_n[0], 1);
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_busy", busy[0], 0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame, D=2
    send(0, 12'hABC, a0);
    wait_frames(0, 1);
    chk("abc_frame", fr_val[0][0], 16'h7ABC);
    chk("abc_bits", fr_bits[0][0], 16);
    chk("abc_cs_low", fr_low[0][0], 68);
    chk("abc_latency", fall_cyc[0] - a0, 2);
    chk("abc_busy_drop", idle_dly[0], D0 * (1 + LD));

    // Back-to-back pair
    send(0, 12'h001, a1);
    send(0, 12'hFFF, a2);
    chk("b2b_accept", a2 - a1, 2);
    wait_frames(0, 3);
    chk("b2b_frame1", fr_val[0][1], 16'h7001);
    chk("b2b_frame2", fr_val[0][2], 16'h7FFF);
    chk("b2b_gap", fr_gap[0][2], D0 * (1 + LD) + 1);

    // Reset in cycle 20 of a frame with a second sample queued
    send(0, 12'h3C3, a0);
    send(0, 12'h0AA, a1);
    a2 = 0;
    while (cs_n[0] && a2 < 100) begin
      @(negedge clk);
      a2++;
    end
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", cs_n[0], 1);
    chk("mid_rst_sclk", sclk[0], 0);
    chk("mid_rst_in_ready", in_ready[0], 1);
    chk("mid_rst_busy", busy[0], 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_hold_clear", busy[0], 0);
    chk("mid_rst_frames", fr_n[0], 4);
    chk("mid_rst_cut", fr_low[0][3] < 68, 1);
    send(0, 12'h555, a0);
    wait_frames(0, 5);
    chk("post_rst_frame", fr_val[0][4], 16'h7555);
    chk("post_rst_bits", fr_bits[0][4], 16);

    // LDAC frame
    send(0, 12'h123, a0);
    wait_frames(0, 6);
    chk("ldac_frame", fr_val[0][5], 16'h7123);
`ifdef DAC_LDAC_EN
    chk("ldac_len", ldac_len[0], 2);
    chk("ldac_ofs", ldac_ofs[0], 2);
`else
    chk("ldac_quiet", ldac_total[0], 0);
`endif

    // Ten frames with in_valid held through each stall
    for (int k = 0; k < 10; k++) send(0, smp[k], acc[k]);
    wait_frames(0, 16);
    for (int k = 0; k < 10; k++) chk($sformatf("run_frame%0d", k), fr_val[0][6 + k], exf[k]);
    chk("run_accept1", acc[1] - acc[0], 2);
    for (int k = 2; k < 10; k++)
      chk($sformatf("run_accept%0d", k), acc[k] - acc[k-1], (35 + LD) * D0 + 1);

    // D=1 instance
    send(1, 12'h800, a0);
    wait_frames(1, 1);
    chk("d1_frame", fr_val[1][0], 16'h7800);
    chk("d1_edges", fr_edges[1][0], 32);
    chk("d1_cs_low", fr_low[1][0], 34);
    chk("d1_busy_drop", idle_dly[1], D1 * (1 + LD));

`ifdef DAC_LDAC_EN
    chk("ldac_pulses0", ldac_pulses[0], 15);
    chk("ldac_pulses1", ldac_pulses[1], 1);
`else
    chk("ldac_const0", ldac_total[0], 0);
    chk("ldac_const1", ldac_total[1], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit=200000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
